lsu_pipe: RTL

- Parametrised load/store unit for the MEM stage of the RV32I five-stage core.
- Replaces the fixed single-cycle, full-word data port with a real byte/halfword/word store path using correct write masks.
- Adds sign/zero-extended loads and a req/gnt/rvalid memory handshake with variable latency.
- Adds a timeout and optional misalignment exception. While an access is in flight it drives a stall to pipeline control.

---
 rtl/lsu_pkg.sv | 40 ++++
 rtl/lsu_align.sv | 38 +++
 rtl/lsu_pipe.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 codes, FSM states
// and byte-lane helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_B:    lane_mask = 4'b0001 << lo;
      F3_H:    lane_mask = 4'b0011 << {lo[1], 1'b0};
      F3_W:    lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: f3_legal = 1'b1;
      F3_BU, F3_HU:     f3_legal = !we;
      default:          f3_legal = 1'b0;
    endcase
  endfunction

  // funct3[1:0] carries the access size for both signed and unsigned loads.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    misaligned = ((f3[1:0] == 2'b01) && lo[0]) || ((f3[1:0] == 2'b10) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: store mask and lane-replicated data, and
// sign/zero-extended load data selected by the low address bits.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic        i_we,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wmask,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = 8'(i_rdata >> {i_addr_lo, 3'b000});
  assign w_half = 16'(i_rdata >> {i_addr_lo[1], 4'b0000});

  always_comb begin
    o_wmask = i_we ? lane_mask(i_funct3, i_addr_lo) : 4'b0000;
    case (i_funct3[1:0])
      2'b00:   o_wdata = {4{i_wdata[7:0]}};
      2'b01:   o_wdata = {2{i_wdata[15:0]}};
      default: o_wdata = i_wdata;
    endcase
    case (i_funct3)
      F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
      F3_BU:   o_rdata = {24'h0, w_byte};
      F3_HU:   o_rdata = {16'h0, w_half};
      default: o_rdata = i_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_pipe.sv
// MEM-stage load/store unit: req/gnt/rvalid handshake FSM with timeout.
// Define LSU_MISALIGN_EXC_EN to trap misaligned accesses instead of aligning them.
module lsu_pipe
  import lsu_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic [4:0]        resp_rd,
  output logic              resp_err,
  output logic              busy,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [3:0]        mem_wmask,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
`ifdef LSU_MISALIGN_EXC_EN
  ,
  output logic              resp_misalign
`endif
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT_CYC == 0) ? '0 : CNT_W'(TIMEOUT_CYC - 1);

  state_t              r_state, w_nxt;
  logic                r_we, r_err;
  logic [2:0]          r_f3;
  logic [ADDR_W-1:0]   r_addr, w_addr_al;
  logic [31:0]         r_wdata, r_rdata;
  logic [4:0]          r_rd;
  logic [CNT_W-1:0]    r_cnt;
  logic                w_accept, w_legal, w_mis, w_to_hit, w_timeout;
  logic [3:0]          w_wmask;
  logic [31:0]         w_wdata, w_ext;

  assign w_accept = req_valid && (r_state == S_IDLE);
  assign w_legal  = f3_legal(req_we, req_funct3);
  assign w_to_hit = (TIMEOUT_CYC != 0) && (r_cnt == TO_LAST);

`ifdef LSU_MISALIGN_EXC_EN
  logic r_mis;
  assign w_mis     = misaligned(req_funct3, req_addr[1:0]);
  assign w_addr_al = req_addr;
`else
  assign w_mis = 1'b0;
  always_comb begin
    w_addr_al = req_addr;
    if (req_funct3[1:0] == 2'b01)      w_addr_al[0]   = 1'b0;
    else if (req_funct3[1:0] == 2'b10) w_addr_al[1:0] = 2'b00;
  end
`endif

  lsu_align u_align (
    .i_funct3  (r_f3),
    .i_we      (r_we),
    .i_addr_lo (r_addr[1:0]),
    .i_wdata   (r_wdata),
    .i_rdata   (mem_rdata),
    .o_wmask   (w_wmask),
    .o_wdata   (w_wdata),
    .o_rdata   (w_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  // A store completes on grant; a load granted on the last allowed cycle still times out.
  always_comb begin
    w_nxt     = r_state;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: if (req_valid) w_nxt = (w_legal && !w_mis) ? S_REQ : S_RESP;
      S_REQ: begin
        if (mem_gnt && r_we) w_nxt = S_RESP;
        else if (w_to_hit) begin
          w_nxt     = S_RESP;
          w_timeout = 1'b1;
        end else if (mem_gnt) w_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rvalid) w_nxt = S_RESP;
        else if (w_to_hit) begin
          w_nxt     = S_RESP;
          w_timeout = 1'b1;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_f3    <= 3'b000;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rd    <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_we    <= req_we;
        r_f3    <= req_funct3;
        r_addr  <= w_addr_al;
        r_wdata <= req_wdata;
        r_rd    <= req_rd;
        r_rdata <= '0;
        r_err   <= !w_legal || w_mis;
      end else if (r_state == S_WAIT && mem_rvalid) begin
        r_rdata <= w_ext;
      end else if (w_timeout) begin
        r_err   <= 1'b1;
      end
      if (r_state == S_REQ || r_state == S_WAIT) r_cnt <= r_cnt + CNT_W'(1);
      else                                       r_cnt <= '0;
    end
  end

`ifdef LSU_MISALIGN_EXC_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_mis <= 1'b0;
    else if (w_accept) r_mis <= w_legal && w_mis;
  end
  assign resp_misalign = resp_valid && r_mis;
`endif

  assign req_ready  = (r_state == S_IDLE);
  assign busy       = !req_ready;
  assign mem_req    = (r_state == S_REQ);
  assign mem_addr   = {r_addr[ADDR_W-1:2], 2'b00};
  assign mem_wen    = mem_req && r_we;
  assign mem_wmask  = mem_req ? w_wmask : 4'b0000;
  assign mem_wdata  = w_wdata;
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = resp_valid ? r_rdata : 32'h0;
  assign resp_rd    = r_rd;
  assign resp_err   = resp_valid && r_err;

endmodule
